// File: rtl/tt_um_richard28277.sv
// 4-bit registered ALU in the Tiny Tapeout user wrapper: A/B on ui_in, opcode on uio_in[3:0].
// Define ALU_MULDIV_EN to build the multiplier and divider (opcodes 2 and 3); otherwise those opcodes return zero.
module tt_um_richard28277 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_ROL  = 4'd10;
   localparam logic [3:0] OP_CMP  = 4'd11;
   localparam logic [3:0] OP_INC  = 4'd12;
   localparam logic [3:0] OP_DEC  = 4'd13;
   localparam logic [3:0] OP_MAX  = 4'd14;
   localparam logic [3:0] OP_PASS = 4'd15;

   logic [3:0] w_a;
   logic [3:0] w_b;
   logic [3:0] w_op;
   logic [1:0] w_sh;
   logic       w_unused;

   assign w_a      = ui_in[7:4];
   assign w_b      = ui_in[3:0];
   assign w_op     = uio_in[3:0];
   assign w_sh     = w_b[1:0];
   assign w_unused = &{1'b0, uio_in[7:4]};

   logic [4:0] w_sum5;
   logic [4:0] w_diff5;
   logic [4:0] w_inc5;
   logic [3:0] w_dec4;
   logic       w_add_v;
   logic       w_sub_v;

   assign w_sum5  = {1'b0, w_a} + {1'b0, w_b};
   assign w_diff5 = {1'b0, w_a} - {1'b0, w_b};
   assign w_inc5  = {1'b0, w_a} + 5'd1;
   assign w_dec4  = w_a - 4'd1;
   // Signed overflow: operands agree in sign (ADD) / differ (SUB) and the result sign flips.
   assign w_add_v = (w_a[3] == w_b[3]) && (w_sum5[3] != w_a[3]);
   assign w_sub_v = (w_a[3] != w_b[3]) && (w_diff5[3] != w_a[3]);

   logic [3:0] w_shl;
   logic [3:0] w_shr;
   logic [3:0] w_rol;
   logic       w_shl_c;
   logic       w_shr_c;

   assign w_shl = w_a << w_sh;
   assign w_shr = w_a >> w_sh;

   always_comb begin
      w_rol   = w_a;
      w_shl_c = 1'b0;
      w_shr_c = 1'b0;
      case (w_sh)
         2'd1: begin
            w_rol   = {w_a[2:0], w_a[3]};
            w_shl_c = w_a[3];
            w_shr_c = w_a[0];
         end
         2'd2: begin
            w_rol   = {w_a[1:0], w_a[3:2]};
            w_shl_c = w_a[2];
            w_shr_c = w_a[1];
         end
         2'd3: begin
            w_rol   = {w_a[0], w_a[3:1]};
            w_shl_c = w_a[1];
            w_shr_c = w_a[2];
         end
         default: begin
            w_rol   = w_a;
            w_shl_c = 1'b0;
            w_shr_c = 1'b0;
         end
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic [7:0] w_prod;
   logic [3:0] w_quot;
   logic [3:0] w_rem;
   logic       w_b_zero;

   assign w_b_zero = (w_b == 4'd0);
   assign w_prod   = {4'd0, w_a} * {4'd0, w_b};
   // Divisor is steered to 1 when zero so the divider never sees a zero operand.
   assign w_quot   = w_a / (w_b_zero ? 4'd1 : w_b);
   assign w_rem    = w_a % (w_b_zero ? 4'd1 : w_b);
`endif

   logic [7:0] w_res;
   logic       w_c;
   logic       w_v;
   logic       w_dz;
   logic       w_z;

   always_comb begin
      w_res = 8'h00;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_dz  = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_res = {3'd0, w_sum5};
            w_c   = w_sum5[4];
            w_v   = w_add_v;
         end
         OP_SUB: begin
            w_res = {4'd0, w_diff5[3:0]};
            w_c   = w_diff5[4];
            w_v   = w_sub_v;
         end
`ifdef ALU_MULDIV_EN
         OP_MUL: w_res = w_prod;
         OP_DIV: begin
            if (w_b_zero) begin
               w_res = {4'hF, w_a};
               w_dz  = 1'b1;
            end else begin
               w_res = {w_quot, w_rem};
            end
         end
`else
         OP_MUL: w_res = 8'h00;
         OP_DIV: w_res = 8'h00;
`endif
         OP_AND: w_res = {4'd0, w_a & w_b};
         OP_OR:  w_res = {4'd0, w_a | w_b};
         OP_XOR: w_res = {4'd0, w_a ^ w_b};
         OP_NOT: w_res = {4'd0, ~w_a};
         OP_SHL: begin
            w_res = {4'd0, w_shl};
            w_c   = w_shl_c;
         end
         OP_SHR: begin
            w_res = {4'd0, w_shr};
            w_c   = w_shr_c;
         end
         OP_ROL: w_res = {4'd0, w_rol};
         OP_CMP: w_res = {5'd0, (w_a > w_b), (w_a == w_b), (w_a < w_b)};
         OP_INC: begin
            w_res = {3'd0, w_inc5};
            w_c   = w_inc5[4];
         end
         OP_DEC: begin
            w_res = {4'd0, w_dec4};
            w_c   = (w_a == 4'd0);
         end
         OP_MAX:  w_res = {4'd0, (w_a > w_b) ? w_a : w_b};
         OP_PASS: w_res = {w_a, w_b};
         default: w_res = 8'h00;
      endcase
   end

   assign w_z = (w_res == 8'h00);

   logic [7:0] r_res;
   logic       r_z;
   logic       r_c;
   logic       r_v;
   logic       r_dz;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_res <= 8'h00;
         r_z   <= 1'b0;
         r_c   <= 1'b0;
         r_v   <= 1'b0;
         r_dz  <= 1'b0;
      end else if (ena) begin
         r_res <= w_res;
         r_z   <= w_z;
         r_c   <= w_c;
         r_v   <= w_v;
         r_dz  <= w_dz;
      end
   end

   assign uo_out  = r_res;
   assign uio_out = {r_dz, r_v, r_c, r_z, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_richard28277.sv
// Self-checking bench for the 4-bit registered ALU; expectations come from an integer reference model via a scoreboard queue.
module tb_tt_um_richard28277;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors;
   int checks;
   logic [15:0] sb_q[$];
   logic [15:0] last_exp;

   tt_um_richard28277 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {uio_out, uo_out} expected one cycle after the operands are presented.
   function automatic logic [15:0] model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      int ai, bi, sa, sb, t, n;
      logic [7:0] r;
      logic c, v, dz;
      ai = int'(a);
      bi = int'(b);
      sa = (ai > 7) ? ai - 16 : ai;
      sb = (bi > 7) ? bi - 16 : bi;
      n  = bi % 4;
      r = 8'h00; c = 1'b0; v = 1'b0; dz = 1'b0; t = 0;
      case (op)
         4'd0: begin
            t = ai + bi; r = 8'(t); c = (t > 15);
            v = ((sa + sb) > 7) || ((sa + sb) < -8);
         end
         4'd1: begin
            t = (ai - bi + 16) % 16; r = 8'(t); c = (ai < bi);
            v = ((sa - sb) > 7) || ((sa - sb) < -8);
         end
`ifdef ALU_MULDIV_EN
         4'd2: r = 8'(ai * bi);
         4'd3: begin
            if (bi == 0) begin
               r = 8'(240 + ai); dz = 1'b1;
            end else begin
               r = 8'((ai / bi) * 16 + (ai % bi));
            end
         end
`else
         4'd2: r = 8'h00;
         4'd3: r = 8'h00;
`endif
         4'd4: r = {4'd0, a & b};
         4'd5: r = {4'd0, a | b};
         4'd6: r = {4'd0, a ^ b};
         4'd7: r = 8'(15 - ai);
         4'd8: begin
            t = ai * (1 << n); r = 8'(t % 16);
            c = (n != 0) ? 1'((t / 16) % 2) : 1'b0;
         end
         4'd9: begin
            r = 8'(ai / (1 << n));
            c = (n != 0) ? 1'((ai / (1 << (n - 1))) % 2) : 1'b0;
         end
         4'd10: r = 8'(((ai * (1 << n)) + (ai / (1 << (4 - n)))) % 16);
         4'd11: r = (ai > bi) ? 8'h04 : ((ai == bi) ? 8'h02 : 8'h01);
         4'd12: begin
            t = ai + 1; r = 8'(t); c = (t > 15);
         end
         4'd13: begin
            r = 8'((ai + 15) % 16); c = (ai == 0);
         end
         4'd14: r = 8'((ai > bi) ? ai : bi);
         default: r = 8'(ai * 16 + bi);
      endcase
      return {dz, v, c, (r == 8'h00), 4'b0000, r};
   endfunction

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      ui_in  = {a, b};
      uio_in = {4'($urandom), op};
      sb_q.push_back(model(a, b, op));
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'hFF;
      uio_in = 8'h0F;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (uo_out !== 8'h00) begin
         errors++; $display("FAIL reset_uo_out got=%h want=00", uo_out);
      end
      checks++;
      if (uio_out !== 8'h00) begin
         errors++; $display("FAIL reset_uio_out got=%h want=00", uio_out);
      end
      checks++;
      if (uio_oe !== 8'hF0) begin
         errors++; $display("FAIL reset_uio_oe got=%h want=F0", uio_oe);
      end
      rst_n = 1'b1;
      last_exp = 16'h0000;
   endtask

   task automatic test_add();
      logic [15:0] exp;
      drive(4'h7, 4'h1, 4'd0);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h08 || uio_out !== 8'h40) begin
         errors++; $display("FAIL add_7_1 got=%h_%h want=%h (R=08 V=1)", uio_out, uo_out, exp);
      end
      drive(4'hF, 4'h1, 4'd0);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h10 || uio_out !== 8'h20) begin
         errors++; $display("FAIL add_F_1 got=%h_%h want=%h (R=10 C=1)", uio_out, uo_out, exp);
      end
      last_exp = exp;
   endtask

   task automatic test_sub_cmp();
      logic [15:0] exp;
      drive(4'h3, 4'h5, 4'd1);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h0E || uio_out[5] !== 1'b1) begin
         errors++; $display("FAIL sub_3_5 got=%h_%h want=%h", uio_out, uo_out, exp);
      end
      drive(4'h9, 4'h9, 4'd11);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h02) begin
         errors++; $display("FAIL cmp_eq got=%h_%h want=%h", uio_out, uo_out, exp);
      end
      last_exp = exp;
   endtask

   task automatic test_muldiv();
      logic [15:0] exp;
      logic [7:0]  want [3];
      logic [7:0]  wflg [3];
      logic [3:0]  va [3];
      logic [3:0]  vb [3];
      logic [3:0]  vop [3];
      va = '{4'hF, 4'hD, 4'h6};
      vb = '{4'hF, 4'h4, 4'h0};
      vop = '{4'd2, 4'd3, 4'd3};
`ifdef ALU_MULDIV_EN
      want = '{8'hE1, 8'h31, 8'hF6};
      wflg = '{8'h00, 8'h00, 8'h80};
`else
      want = '{8'h00, 8'h00, 8'h00};
      wflg = '{8'h10, 8'h10, 8'h10};
`endif
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], vop[i]);
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         checks++;
         if ({uio_out, uo_out} !== exp || uo_out !== want[i] || uio_out !== wflg[i]) begin
            errors++;
            $display("FAIL muldiv_%0d got=%h_%h want=%h_%h", i, uio_out, uo_out, wflg[i], want[i]);
         end
         last_exp = exp;
      end
   endtask

   task automatic test_shift_logic();
      logic [15:0] exp;
      logic [7:0]  want [3];
      logic [7:0]  wflg [3];
      logic [3:0]  va [3];
      logic [3:0]  vb [3];
      logic [3:0]  vop [3];
      va   = '{4'h9, 4'h9, 4'h5};
      vb   = '{4'h1, 4'h1, 4'h5};
      vop  = '{4'd8, 4'd10, 4'd6};
      want = '{8'h02, 8'h03, 8'h00};
      wflg = '{8'h20, 8'h00, 8'h10};
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], vop[i]);
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         checks++;
         if ({uio_out, uo_out} !== exp || uo_out !== want[i] || uio_out !== wflg[i]) begin
            errors++;
            $display("FAIL shiftlogic_%0d got=%h_%h want=%h_%h", i, uio_out, uo_out, wflg[i], want[i]);
         end
         last_exp = exp;
      end
   endtask

   task automatic test_enable_hold();
      logic [15:0] exp;
      drive(4'h5, 4'hA, 4'd15);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if (uo_out !== 8'h5A || {uio_out, uo_out} !== exp) begin
         errors++; $display("FAIL hold_setup got=%h_%h want=%h", uio_out, uo_out, exp);
      end
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ui_in  = 8'($urandom);
         uio_in = 8'($urandom);
         @(posedge clk); #1;
         checks++;
         if (uo_out !== 8'h5A || uio_out !== 8'h00) begin
            errors++; $display("FAIL hold_cycle_%0d got=%h_%h want=00_5a", i, uio_out, uo_out);
         end
      end
      ena = 1'b1;
      drive(4'hF, 4'h0, 4'd12);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h10) begin
         errors++; $display("FAIL hold_release got=%h_%h want=%h", uio_out, uo_out, exp);
      end
      last_exp = exp;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      logic [3:0]  a, b, op;
      for (int i = 0; i < 160; i++) begin
         a  = 4'($urandom);
         b  = 4'($urandom);
         op = 4'(i % 16);
         if (i < 32) b = 4'(i / 16);
         ena = ($urandom_range(0, 7) != 0);
         if (ena) begin
            drive(a, b, op);
         end else begin
            ui_in  = {a, b};
            uio_in = {4'($urandom), op};
            sb_q.push_back(last_exp);
         end
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         checks++;
         if ({uio_out, uo_out} !== exp) begin
            errors++;
            $display("FAIL b2b_%0d a=%h b=%h op=%0d ena=%b got=%h_%h want=%h", i, a, b, op, ena, uio_out, uo_out, exp);
         end
         last_exp = exp;
      end
      ena = 1'b1;
   endtask

   task automatic test_reset_midstream();
      logic [15:0] exp;
      drive(4'hF, 4'hF, 4'd12);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h10) begin
         errors++; $display("FAIL pre_reset got=%h_%h want=%h", uio_out, uo_out, exp);
      end
      ui_in  = 8'hF1;
      uio_in = 8'h00;
      rst_n  = 1'b0;
      sb_q.push_back(16'h0000);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uio_oe !== 8'hF0) begin
         errors++; $display("FAIL mid_reset got=%h_%h oe=%h want=%h oe=f0", uio_out, uo_out, uio_oe, exp);
      end
      rst_n = 1'b1;
      drive(4'h0, 4'h0, 4'd13);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if ({uio_out, uo_out} !== exp || uo_out !== 8'h0F || uio_out !== 8'h20) begin
         errors++; $display("FAIL post_reset_dec got=%h_%h want=%h", uio_out, uo_out, exp);
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      last_exp = 16'h0000;
      rst_n    = 1'b0;
      ena      = 1'b1;
      ui_in    = 8'h00;
      uio_in   = 8'h00;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_sub_cmp();
      test_muldiv();
      test_shift_logic();
      test_enable_hold();
      test_back_to_back();
      test_reset_midstream();
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
      end
      checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tt_um_richard28277.md
Name: tt_um_richard28277

Overview:
- 4-bit registered ALU in the Tiny Tapeout user-project wrapper.
- Operands A and B arrive on the dedicated inputs; a 4-bit opcode arrives on the low bidirectional pins.
- The 8-bit result is registered onto the dedicated outputs; status flags are registered onto the upper bidirectional pins.

Parameters:
- None. Operand width is fixed at 4 bits and result width at 8 bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  design enable; registers update only when high.
- ui_in  input  8  ui_in[7:4] = A, ui_in[3:0] = B (both unsigned unless noted).
- uo_out  output  8  registered ALU result R.
- uio_in  input  8  uio_in[3:0] = opcode; uio_in[7:4] ignored.
- uio_out  output  8  [4] Z zero, [5] C carry/borrow/shift-out, [6] V signed overflow, [7] DZ divide-by-zero; [3:0] driven 0.
- uio_oe  output  8  constant 8'hF0 (upper nibble outputs, lower nibble inputs), independent of reset.

Behaviour:
- One clock, synchronous active-low reset; all state changes on the rising edge of clk.
- When rst_n = 0 at a rising edge: uo_out = 8'h00 and flags Z, C, V, DZ = 0. Reset has priority over ena.
- When rst_n = 1 and ena = 1: R and flags are computed combinationally from the current A, B and opcode and registered. Latency is 1 cycle; a new operation is accepted every cycle.
- When ena = 0: uo_out and flags hold their values.
- Reset asserted mid-stream clears the outputs at that edge; there is no other state.
- Opcodes, with R zero-extended to 8 bits unless stated:
  - 0 ADD: R = A+B (5 bits); C = bit 4; V = 4-bit signed overflow.
  - 1 SUB: R[3:0] = A-B mod 16; R[7:4] = 0; C = borrow (A<B); V = 4-bit signed overflow.
  - 2 MUL: R = A*B (8-bit unsigned product).
  - 3 DIV: R[7:4] = A/B, R[3:0] = A%B. If B = 0: R = {4'hF, A} and DZ = 1.
  - 4 AND: R = A & B.
  - 5 OR: R = A | B.
  - 6 XOR: R = A ^ B.
  - 7 NOT: R = ~A (4 bits).
  - 8 SHL: R[3:0] = A << B[1:0]; C = last bit shifted out (0 if shift is 0).
  - 9 SHR: R[3:0] = A >> B[1:0], logical; C = last bit shifted out (0 if shift is 0).
  - 10 ROL: R[3:0] = A rotated left by B[1:0].
  - 11 CMP: R = {5'b0, A>B, A==B, A<B}, unsigned.
  - 12 INC: R = A+1 (5 bits); C = R[4].
  - 13 DEC: R[3:0] = A-1 mod 16; C = (A==0).
  - 14 MAX: R = larger of A and B, unsigned.
  - 15 PASS: R = {A,B}.
- Flags not listed for an opcode are 0.
- Z = (R == 8'h00) for every opcode, including DIV with B = 0.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: opcodes 2 and 3 behave as specified above.
- Undefined: no multiplier or divider is built. Opcodes 2 and 3 return R = 8'h00 with Z = 1, DZ = 0 and all other flags 0. All other opcodes are unchanged.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with ena = 1 and ui_in = 8'hFF -> uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hF0.
- ADD: A = 7, B = 1, opcode 0 -> next cycle R = 8'h08, C = 0, V = 1, Z = 0. Then A = F, B = 1 -> R = 8'h10, C = 1, V = 0.
- SUB/CMP: A = 3, B = 5, opcode 1 -> R = 8'h0E, C = 1. Then opcode 11 with A = B = 9 -> R = 8'h02.
- MUL/DIV (macro defined): A = F, B = F, opcode 2 -> R = 8'hE1. A = D, B = 4, opcode 3 -> R = 8'h31. A = 6, B = 0, opcode 3 -> R = 8'hF6, DZ = 1.
- Shifts/logic: A = 9, B = 1, opcode 8 -> R = 8'h02, C = 1. Opcode 10 -> R = 8'h03. A = 5, B = 5, opcode 6 -> R = 8'h00, Z = 1.
- Enable hold: produce R = 8'h5A with opcode 15 (A = 5, B = A), drop ena, then change inputs for 3 cycles -> uo_out stays 8'h5A. Re-raise ena -> updates next cycle.
